bcd_serial_subtractor: RTL and testbench



---
 rtl/bcd_pkg.sv | 10 +
 rtl/bcd_digit_sub.sv | 18 +
 rtl/bcd_serial_subtractor.sv | 88 ++++++++
 tb/tb_bcd_serial_subtractor.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, FSM state encoding and digit check
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;
  localparam int BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int BCD_RADIX = 10;
  function automatic logic digit_ok(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: one-digit decimal subtract with borrow in/out
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             bin,
  output logic [BCD_W-1:0] d,
  output logic             bout
);
  logic [BCD_W:0] t;
  // binary difference; a negative result wraps mod 16, so adding the radix to the low nibble lands on t+10
  always_comb begin
    t = {1'b0, a} - {1'b0, b} - {{BCD_W{1'b0}}, bin};
    bout = t[BCD_W];
    d = bout ? t[BCD_W-1:0] + BCD_W'(BCD_RADIX) : t[BCD_W-1:0];
  end
endmodule

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial packed-BCD A-B-Bin with optional sign-magnitude pass
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit MAG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BCD_W*DIGITS-1:0] A,
  input  logic [BCD_W*DIGITS-1:0] B,
  input  logic                    Bin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BCD_W*DIGITS-1:0] Diff,
  output logic                    Bout,
  output logic                    Err
);
  localparam int W = BCD_W * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  state_t state, state_n;
  logic [W-1:0] a_sr, b_sr, d;
  logic [CW-1:0] cnt;
  logic borrow, bout_r, err_r, bad, accept, last, dig_bout;
  logic [BCD_W-1:0] dig_a, dig_b, dig_d;
  // NEG reuses the digit subtractor as 0 - D_i - borrow on the result register
  assign dig_a = state == NEG ? '0 : a_sr[BCD_W-1:0];
  assign dig_b = state == NEG ? d[BCD_W-1:0] : b_sr[BCD_W-1:0];
  bcd_digit_sub u_dig (.a(dig_a), .b(dig_b), .bin(borrow), .d(dig_d), .bout(dig_bout));
  assign accept = in_valid & in_ready;
  assign last = cnt == CW'(DIGITS - 1);
  // flag any operand digit above 9
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | !digit_ok(A[i*BCD_W +: BCD_W]) | !digit_ok(B[i*BCD_W +: BCD_W]);
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next-state logic
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = bad ? DONE : SUB;
    if (state == SUB && last) state_n = (dig_bout && MAG) ? NEG : DONE;
    if (state == NEG && last) state_n = DONE;
    if (state == DONE && out_ready) state_n = IDLE;
  end
  // handshake and result outputs
  always_comb begin
    in_ready = state == IDLE && !rst;
    out_valid = state == DONE;
    Diff = d;
    Bout = bout_r;
    Err = err_r;
  end
  // operand capture, per-digit shifting of operands/result, borrow and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      d <= '0;
      cnt <= '0;
      borrow <= 1'b0;
      bout_r <= 1'b0;
      err_r <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        a_sr <= A;
        b_sr <= B;
        d <= '0;
        cnt <= '0;
        borrow <= Bin;
        bout_r <= 1'b0;
        err_r <= bad;
      end
    end else if (state == SUB || state == NEG) begin
      a_sr <= a_sr >> BCD_W;
      b_sr <= b_sr >> BCD_W;
      d <= W'({dig_d, d} >> BCD_W);
      cnt <= last ? '0 : cnt + CW'(1);
      borrow <= (state == SUB && last) ? 1'b0 : dig_bout;
      if (state == SUB && last) bout_r <= dig_bout;
    end
  end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor: scoreboard bench running MAG=1 and MAG=0 instances side by side
module tb_bcd_serial_subtractor;
  typedef struct {
    logic [15:0] diff;
    logic bout;
    logic err;
    int lat;
    int acc;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, Bin = 0, bp = 0;
  logic [15:0] A = 0, B = 0;
  logic [1:0] ir, ov, rdy, bo, er;
  logic [15:0] df[2];
  bit seen[2];
  int cyc = 0, checks = 0, errors = 0;
  exp_t q0[$], q1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bcd_serial_subtractor #(.DIGITS(4), .MAG(1)) u_mag (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .A(A), .B(B), .Bin(Bin),
    .out_valid(ov[0]), .out_ready(rdy[0]), .Diff(df[0]), .Bout(bo[0]), .Err(er[0]));
  bcd_serial_subtractor #(.DIGITS(4), .MAG(0)) u_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .A(A), .B(B), .Bin(Bin),
    .out_valid(ov[1]), .out_ready(rdy[1]), .Diff(df[1]), .Bout(bo[1]), .Err(er[1]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // decimal reference: decode, subtract as integers, re-encode
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin, input bit mag);
    exp_t e;
    int av = 0, bv = 0, d;
    bit bad = 0;
    for (int i = 3; i >= 0; i--) begin
      if (a[i*4 +: 4] > 9 || b[i*4 +: 4] > 9) bad = 1;
      av = av * 10 + int'(a[i*4 +: 4]);
      bv = bv * 10 + int'(b[i*4 +: 4]);
    end
    e.acc = cyc;
    if (bad) begin
      e.diff = 0; e.bout = 0; e.err = 1; e.lat = 1;
      return e;
    end
    d = av - bv - int'(bin);
    e.err = 0;
    e.bout = d < 0;
    if (d < 0) d = mag ? -d : d + 10000;
    for (int i = 0; i < 4; i++) begin
      e.diff[i*4 +: 4] = 4'(d % 10);
      d = d / 10;
    end
    e.lat = (e.bout && mag) ? 9 : 5;
    return e;
  endfunction
  // monitor: compare every presented result against the queue head, pop on handshake
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        seen[k] = 0;
        rdy[k] = 0;
      end else begin
        rdy[k] = !bp && ($urandom_range(3) != 0);
        if (ov[k]) begin
          if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out dut%0d: got out_valid=1 expected 0", k);
          end else begin
            exp_t e;
            e = k == 0 ? q0[0] : q1[0];
            if (!seen[k]) begin
              chk($sformatf("latency dut%0d", k), cyc - e.acc, e.lat);
              seen[k] = 1;
            end
            chk($sformatf("result dut%0d", k), {14'b0, df[k], bo[k], er[k]}, {14'b0, e.diff, e.bout, e.err});
            if (rdy[k]) begin
              if (k == 0) void'(q0.pop_front());
              else void'(q1.pop_front());
              seen[k] = 0;
            end
          end
        end
      end
    end
  end
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int n = 0;
    while (!(ir[0] && ir[1]) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("send_timeout", 0, 1);
    A = a; B = b; Bin = bin; in_valid = 1;
    q0.push_back(model(a, b, bin, 1));
    q1.push_back(model(a, b, bin, 0));
    @(negedge clk);
    #1;
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q0.size() || q1.size()) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
  endtask
  function automatic logic [15:0] rnd_op();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[i*4 +: 4] = ($urandom_range(15) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(9));
    return v;
  endfunction
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset in_ready", {30'b0, ir}, 0);
    chk("reset out_valid", {30'b0, ov}, 0);
    chk("reset outputs", {df[0], df[1]}, 0);
    chk("reset flags", {28'b0, bo, er}, 0);
    rst = 0;
    #1;
    chk("in_ready after reset", {30'b0, ir}, 3);
    send(16'h0057, 16'h0042, 0);
    send(16'h0042, 16'h0057, 0);
    send(16'h0000, 16'h0000, 1);
    send(16'h1234, 16'h1234, 0);
    send(16'h00A3, 16'h0001, 0);
    send(16'h9999, 16'h0000, 1);
    send(16'h0000, 16'h9999, 0);
    drain();
    bp = 1;
    send(16'h0057, 16'h0042, 0);
    begin
      int n = 0;
      while (ov != 2'b11 && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (n >= 20) chk("bp_timeout", 0, 1);
    end
    for (int i = 0; i < 10; i++) begin
      A = 16'($urandom); B = 16'($urandom); in_valid = ~in_valid;
      @(negedge clk);
      #1;
      chk("bp in_ready", {30'b0, ir}, 0);
    end
    in_valid = 0;
    bp = 0;
    drain();
    @(negedge clk);
    #1;
    chk("ready after release", {30'b0, ir}, 3);
    send(16'h4321, 16'h1234, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    chk("abort out_valid", {30'b0, ov}, 0);
    chk("abort diff", {df[0], df[1]}, 0);
    chk("abort in_ready", {30'b0, ir}, 0);
    q0.delete();
    q1.delete();
    rst = 0;
    #1;
    chk("in_ready after abort", {30'b0, ir}, 3);
    send(16'h0100, 16'h0001, 0);
    for (int i = 0; i < 60; i++) send(rnd_op(), rnd_op(), 1'($urandom_range(1)));
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
